// File: rtl/act_word_packer.sv
// act_word_packer: packs narrow activation beats MSB-first into wide words and
// emits them as single-cycle pulses spaced at least GAP cycles apart via a small FIFO.
module act_word_packer #(
  parameter int ELEM_W   = 2,
  parameter int IN_ELEMS = 2,
  parameter int WORD_W   = 128,
  parameter int DEPTH    = 2,
  parameter int GAP      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_in,
  input  logic                       last_in,
  input  logic [IN_ELEMS*ELEM_W-1:0] data_in,
  output logic                       rdy_in,
  output logic                       vld_out,
  output logic [WORD_W-1:0]          data_out
);
  localparam int N  = WORD_W / ELEM_W;
  localparam int BW = IN_ELEMS * ELEM_W;
  localparam int CW = $clog2(N + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int GW = $clog2(GAP + 1);
  logic [CW-1:0]     cnt, cnt_nx;
  logic [WORD_W-1:0] pack, word;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [FW-1:0]     fcnt;
  logic [GW-1:0]     gap;
  logic              acc, push, pop;
  always_comb begin
    acc    = vld_in & rdy_in;
    cnt_nx = cnt + CW'(IN_ELEMS);
    word   = pack | ({data_in, {(WORD_W-BW){1'b0}}} >> (int'(cnt) * ELEM_W));
    push   = acc & (last_in | (cnt_nx == CW'(N)));
    pop    = (fcnt != '0) && (gap == '0);
  end
  assign rdy_in = fcnt != FW'(DEPTH);
  always_ff @(posedge clk)
    if (push) mem[wp] <= word;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      pack     <= '0;
      wp       <= '0;
      rp       <= '0;
      fcnt     <= '0;
      gap      <= '0;
      vld_out  <= 1'b0;
      data_out <= '0;
    end else begin
      if (acc) begin
        pack <= push ? '0 : word;
        cnt  <= push ? '0 : cnt_nx;
      end
      if (push) wp <= wp == PW'(DEPTH-1) ? '0 : wp + 1'b1;
      // a pop only ever reads an entry written on an earlier edge
      if (pop) begin
        data_out <= mem[rp];
        rp       <= rp == PW'(DEPTH-1) ? '0 : rp + 1'b1;
        gap      <= GW'(GAP-1);
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      vld_out <= pop;
      fcnt    <= fcnt + FW'(push) - FW'(pop);
    end
  end
endmodule

// File: tb/tb_act_word_packer.sv
// tb_act_word_packer: directed stimulus with a reference packer model feeding a
// scoreboard of expected words, checked whenever the DUT pulses vld_out.
module tb_act_word_packer;
  localparam int EW = 2, IE = 2, WW = 128, GP = 64, BW = EW*IE;
  logic clk = 0, rst = 0, vld_in = 0, last_in = 0;
  logic [BW-1:0] data_in = '0;
  logic rdy_in, vld_out;
  logic [WW-1:0] data_out;
  int n_assert = 0, n_fail = 0, n_pulse = 0, cyc = 0;
  logic [WW-1:0] sb[$];
  int pulse_t[$];
  logic [WW-1:0] mw = '0, exp_w;
  int mc = 0;
  logic prev_vld = 0;

  act_word_packer dut (.clk(clk), .rst(rst), .vld_in(vld_in), .last_in(last_in),
    .data_in(data_in), .rdy_in(rdy_in), .vld_out(vld_out), .data_out(data_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      n_assert++;
      assert (!(vld_out && prev_vld)) else begin n_fail++; $error("FAIL pulse_width: got 2-cycle vld_out exp 1"); end
      if (vld_out) begin
        n_pulse++;
        pulse_t.push_back(cyc);
        if (pulse_t.size() >= 2) begin
          n_assert++;
          assert (pulse_t[$] - pulse_t[$-1] >= GP) else begin n_fail++;
            $error("FAIL gap: got %0d exp >=%0d", pulse_t[$] - pulse_t[$-1], GP); end
        end
        n_assert++;
        assert (sb.size() > 0) else begin n_fail++; $error("FAIL unexpected_word: got %h exp none", data_out); end
        if (sb.size() > 0) begin
          exp_w = sb.pop_front();
          n_assert++;
          assert (data_out === exp_w) else begin n_fail++; $error("FAIL word: got %h exp %h", data_out, exp_w); end
        end
      end
    end
    prev_vld = vld_out;
  end

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin n_fail++; $error("FAIL %s: got %h exp %h", tag, got, exp); end
  endtask

  task automatic send(input logic [BW-1:0] d, input logic l);
    vld_in = 1; last_in = l;
    for (int g = 0; !rdy_in && g < 500; g++) begin
      data_in = BW'($urandom);
      @(negedge clk);
    end
    chk("stall_timeout", WW'(rdy_in), WW'(1));
    data_in = d;
    @(negedge clk);
    for (int j = 0; j < IE; j++) begin
      mw[WW-1-EW*mc -: EW] = d[BW-1-EW*j -: EW];
      mc++;
    end
    if (mc == WW/EW || l) begin
      sb.push_back(mw);
      mw = '0; mc = 0;
    end
  endtask

  task automatic idle(input int n);
    vld_in = 0; last_in = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int i;
    vld_in = 0; last_in = 0;
    for (i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", WW'(sb.size()), WW'(0));
    repeat (GP + 2) @(negedge clk);
  endtask

  initial begin
    int p0, b;
    repeat (3) @(negedge clk);
    chk("rst_vld", WW'(vld_out), WW'(0));
    chk("rst_data", data_out, '0);
    chk("rst_rdy", WW'(rdy_in), WW'(1));
    rst = 1;
    @(negedge clk);
    // 1: full word of repeating 0,1,2,3 elements
    p0 = n_pulse;
    for (int i = 0; i < 32; i++) send(i % 2 ? 4'b1011 : 4'b0001, 0);
    drain();
    chk("t1_pulses", WW'(n_pulse - p0), WW'(1));
    chk("t1_data", data_out, {16{8'h1B}});
    // 2: early close with last_in
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) send(4'b1111, i == 2);
    drain();
    chk("t2_pulses", WW'(n_pulse - p0), WW'(1));
    chk("t2_data", data_out, {12'hFFF, 116'h0});
    // 3: back-to-back beats fill the FIFO
    p0 = n_pulse;
    b = pulse_t.size();
    for (int i = 0; i < 96; i++) send(BW'($urandom), 0);
    chk("t3_rdy_full", WW'(rdy_in), WW'(0));
    // 6: stalled beat with changing data is packed once
    for (int i = 0; i < 32; i++) send(BW'($urandom), 0);
    drain();
    chk("t3_pulses", WW'(n_pulse - p0), WW'(4));
    chk("t3_space1", WW'(pulse_t[b+1] - pulse_t[b]), WW'(GP));
    chk("t3_space2", WW'(pulse_t[b+2] - pulse_t[b+1]), WW'(GP));
    // 5: last_in on the filling beat yields exactly one word
    p0 = n_pulse;
    for (int i = 0; i < 32; i++) send(BW'($urandom), i == 31);
    drain();
    chk("t5_pulses", WW'(n_pulse - p0), WW'(1));
    // 4: reset mid-word discards partial state
    for (int i = 0; i < 10; i++) send(4'b1110, 0);
    idle(0);
    rst = 0;
    #1;
    chk("t4_rst_vld", WW'(vld_out), WW'(0));
    chk("t4_rst_data", data_out, '0);
    chk("t4_rst_rdy", WW'(rdy_in), WW'(1));
    sb.delete(); pulse_t.delete(); mw = '0; mc = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    p0 = n_pulse;
    for (int i = 0; i < 32; i++) send(4'b0101, 0);
    drain();
    chk("t4_pulses", WW'(n_pulse - p0), WW'(1));
    chk("t4_data", data_out, {64{2'b01}});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
